wb_xbar_n: RTL and testbench

- Single-master, N-slave Wishbone (pipelined) crossbar. Generalises the existing 1:2 crossbar to a parametrised slave count, data width and select field.
- Adds three things the 1:2 block lacks: decode-miss error, slave ERR forwarding, and a bus timeout.
- One transaction in flight at a time. Sits between the host Wishbone master and the peripheral/core slaves.

---
 rtl/wb_xbar_n.sv | 197 +++++++++++++++++++
 tb/tb_wb_xbar_n.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_xbar_n.sv
// Single-master, N-slave pipelined Wishbone crossbar with decode-miss error,
// slave ERR forwarding and an optional bus timeout. One transaction in flight.
module wb_xbar_n #(
  parameter int NSLAVES = 4,
  parameter int DW      = 8,
  parameter int AW      = 32,
  parameter int SELW    = DW / 8,
  parameter int IDX_LSB = 18,
  parameter int TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  WBM_CYC,
  input  logic                  WBM_STB,
  input  logic                  WBM_WE,
  input  logic [AW-1:0]         WBM_ADDR,
  input  logic [DW-1:0]         WBM_WDATA,
  input  logic [SELW-1:0]       WBM_SEL,
  output logic                  WBM_STALL,
  output logic                  WBM_ACK,
  output logic [DW-1:0]         WBM_RDATA,
  output logic                  WBM_ERR,
  output logic [NSLAVES-1:0]    WBS_CYC,
  output logic [NSLAVES-1:0]    WBS_STB,
  output logic                  WBS_WE,
  output logic [AW-1:0]         WBS_ADDR,
  output logic [DW-1:0]         WBS_WDATA,
  output logic [SELW-1:0]       WBS_SEL,
  input  logic [NSLAVES-1:0]    WBS_STALL,
  input  logic [NSLAVES-1:0]    WBS_ACK,
  input  logic [NSLAVES*DW-1:0] WBS_RDATA,
  input  logic [NSLAVES-1:0]    WBS_ERR
);

  localparam int IDXW = $clog2(NSLAVES);
  localparam int TW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [IDXW:0] NS_LIM = (IDXW + 1)'(NSLAVES);

  typedef enum logic [1:0] {IDLE, BUSY, DERR, PAD} state_t;

  state_t              state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [NSLAVES-1:0]  cyc_q, cyc_d, stb_q, stb_d;
  logic                we_q, we_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [SELW-1:0]     sel_q, sel_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                ack_q, ack_d, err_q, err_d;
  logic [TW-1:0]       cnt_q, cnt_d;

  logic [IDXW-1:0]     addr_idx;
  logic                miss;
  logic [NSLAVES-1:0]  dec;
  logic                ack_sel, err_sel, stall_sel;
  logic [DW-1:0]       rdata_sel;
  logic [TW-1:0]       cnt_inc;
  logic                to_hit;

  assign addr_idx = WBM_ADDR[IDX_LSB +: IDXW];
  assign miss     = ({1'b0, addr_idx} >= NS_LIM);
  assign cnt_inc  = cnt_q + 1'b1;
  assign to_hit   = (TIMEOUT != 0) && (cnt_inc == TW'(TIMEOUT));

  // Decode of the incoming request and mux of the selected slave's responses;
  // responses from any other slave never reach the FSM.
  always_comb begin
    dec       = '0;
    ack_sel   = 1'b0;
    err_sel   = 1'b0;
    stall_sel = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      dec[i] = (addr_idx == IDXW'(i));
      if (idx_q == IDXW'(i)) begin
        ack_sel   = WBS_ACK[i];
        err_sel   = WBS_ERR[i];
        stall_sel = WBS_STALL[i];
        rdata_sel = WBS_RDATA[i*DW +: DW];
      end
    end
  end

  // NOTE: every next-state value gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (WBM_CYC && WBM_STB) begin
          we_d    = WBM_WE;
          addr_d  = WBM_ADDR;
          wdata_d = WBM_WDATA;
          sel_d   = WBM_SEL;
          idx_d   = addr_idx;
          cnt_d   = '0;
          if (miss) begin
            state_d = DERR;
          end else begin
            cyc_d   = dec;
            stb_d   = dec;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!WBM_CYC) begin
          cyc_d   = '0;
          stb_d   = '0;
          state_d = IDLE;
        end else if (err_sel) begin
          cyc_d   = '0;
          stb_d   = '0;
          err_d   = 1'b1;
          state_d = PAD;
        end else if (ack_sel) begin
          cyc_d   = '0;
          stb_d   = '0;
          ack_d   = 1'b1;
          if (!we_q) rdata_d = rdata_sel;
          state_d = PAD;
        end else if (to_hit) begin
          cyc_d   = '0;
          stb_d   = '0;
          err_d   = 1'b1;
          state_d = PAD;
        end else begin
          cnt_d = cnt_inc;
          if (!stall_sel) stb_d = '0;
        end
      end
      DERR: begin
        err_d   = 1'b1;
        state_d = PAD;
      end
      PAD: begin
        if (!WBM_CYC && !WBM_STB) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cyc_q   <= '0;
      stb_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign WBM_STALL = !((state_q == IDLE) && !ack_q && !err_q);
  assign WBM_ACK   = ack_q;
  assign WBM_ERR   = err_q;
  assign WBM_RDATA = rdata_q;
  assign WBS_CYC   = cyc_q;
  assign WBS_STB   = stb_q;
  assign WBS_WE    = we_q;
  assign WBS_ADDR  = addr_q;
  assign WBS_WDATA = wdata_q;
  assign WBS_SEL   = sel_q;

endmodule

// File: tb/tb_wb_xbar_n.sv
// Directed bench for wb_xbar_n built with 3 slaves and an 8-cycle timeout;
// inputs change and outputs are checked on the falling clock edge.
module tb_wb_xbar_n;

  localparam int NS = 3;
  localparam int DW = 8;
  localparam int AW = 32;

  logic            CLK = 1'b0;
  logic            RSTN;
  logic            WBM_CYC, WBM_STB, WBM_WE;
  logic [AW-1:0]   WBM_ADDR;
  logic [DW-1:0]   WBM_WDATA;
  logic [0:0]      WBM_SEL;
  logic            WBM_STALL, WBM_ACK, WBM_ERR;
  logic [DW-1:0]   WBM_RDATA;
  logic [NS-1:0]   WBS_CYC, WBS_STB;
  logic            WBS_WE;
  logic [AW-1:0]   WBS_ADDR;
  logic [DW-1:0]   WBS_WDATA;
  logic [0:0]      WBS_SEL;
  logic [NS-1:0]   WBS_STALL, WBS_ACK, WBS_ERR;
  logic [NS*DW-1:0] WBS_RDATA;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  wb_xbar_n #(.NSLAVES(NS), .DW(DW), .AW(AW), .IDX_LSB(18), .TIMEOUT(8)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .WBM_CYC(WBM_CYC), .WBM_STB(WBM_STB), .WBM_WE(WBM_WE),
    .WBM_ADDR(WBM_ADDR), .WBM_WDATA(WBM_WDATA), .WBM_SEL(WBM_SEL),
    .WBM_STALL(WBM_STALL), .WBM_ACK(WBM_ACK), .WBM_RDATA(WBM_RDATA),
    .WBM_ERR(WBM_ERR),
    .WBS_CYC(WBS_CYC), .WBS_STB(WBS_STB), .WBS_WE(WBS_WE),
    .WBS_ADDR(WBS_ADDR), .WBS_WDATA(WBS_WDATA), .WBS_SEL(WBS_SEL),
    .WBS_STALL(WBS_STALL), .WBS_ACK(WBS_ACK), .WBS_RDATA(WBS_RDATA),
    .WBS_ERR(WBS_ERR)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic request(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    WBM_CYC   = 1'b1;
    WBM_STB   = 1'b1;
    WBM_WE    = we;
    WBM_ADDR  = addr;
    WBM_WDATA = wd;
    WBM_SEL   = 1'b1;
    tick();
    WBM_STB = 1'b0;
  endtask

  task automatic release_bus();
    WBM_CYC = 1'b0;
    tick();
    check("idle_stall", 32'(WBM_STALL), 32'h0);
  endtask

  initial begin
    RSTN = 1'b0;
    WBM_CYC = 1'b0; WBM_STB = 1'b0; WBM_WE = 1'b0;
    WBM_ADDR = '0; WBM_WDATA = '0; WBM_SEL = '0;
    WBS_STALL = '0; WBS_ACK = '0; WBS_ERR = '0; WBS_RDATA = '0;
    tick(); tick();
    check("rst_cyc",   32'(WBS_CYC),   32'h0);
    check("rst_stb",   32'(WBS_STB),   32'h0);
    check("rst_ack",   32'(WBM_ACK),   32'h0);
    check("rst_err",   32'(WBM_ERR),   32'h0);
    check("rst_rdata", 32'(WBM_RDATA), 32'h0);
    check("rst_addr",  WBS_ADDR,       32'h0);
    RSTN = 1'b1;
    tick();
    check("rst_stall", 32'(WBM_STALL), 32'h0);

    // Write to slave 2, ACK three cycles after STB.
    request(1'b1, 32'h0008_0000, 8'hA5);
    check("wr_cyc",   32'(WBS_CYC),   32'h4);
    check("wr_stb",   32'(WBS_STB),   32'h4);
    check("wr_wdata", 32'(WBS_WDATA), 32'hA5);
    check("wr_we",    32'(WBS_WE),    32'h1);
    check("wr_addr",  WBS_ADDR,       32'h0008_0000);
    check("wr_stall", 32'(WBM_STALL), 32'h1);
    tick();
    check("wr_stb_drop", 32'(WBS_STB), 32'h0);
    check("wr_cyc_hold", 32'(WBS_CYC), 32'h4);
    tick();
    check("wr_no_ack_yet", 32'(WBM_ACK), 32'h0);
    WBS_ACK = 3'b100;
    tick();
    WBS_ACK = 3'b000;
    check("wr_ack",     32'(WBM_ACK), 32'h1);
    check("wr_err",     32'(WBM_ERR), 32'h0);
    check("wr_cyc_clr", 32'(WBS_CYC), 32'h0);
    tick();
    check("wr_ack_pulse", 32'(WBM_ACK), 32'h0);
    release_bus();

    // Read from slave 1; other slices carry distinct data.
    WBS_RDATA = {8'h11, 8'h3C, 8'h22};
    request(1'b0, 32'h0004_0000, 8'h00);
    check("rd_cyc", 32'(WBS_CYC), 32'h2);
    WBS_ACK = 3'b010;
    tick();
    WBS_ACK = 3'b000;
    check("rd_ack",   32'(WBM_ACK),   32'h1);
    check("rd_rdata", 32'(WBM_RDATA), 32'h3C);
    tick();
    check("rd_pad_stall", 32'(WBM_STALL), 32'h1);
    tick();
    check("rd_pad_stall2", 32'(WBM_STALL), 32'h1);
    check("rd_rdata_hold", 32'(WBM_RDATA), 32'h3C);
    release_bus();

    // Slave 0 stalls for four sampled cycles, then ACKs.
    WBS_STALL = 3'b001;
    request(1'b1, 32'h0000_0000, 8'h5A);
    check("st_cyc", 32'(WBS_CYC), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("st_stb_held", 32'(WBS_STB), 32'h1);
    end
    WBS_STALL = 3'b000;
    tick();
    check("st_stb_drop", 32'(WBS_STB), 32'h0);
    check("st_cyc_hold", 32'(WBS_CYC), 32'h1);
    WBS_ACK = 3'b001;
    tick();
    WBS_ACK = 3'b000;
    check("st_ack", 32'(WBM_ACK), 32'h1);
    check("st_cyc_clr", 32'(WBS_CYC), 32'h0);
    release_bus();

    // Decode miss: index 3 with only three slaves.
    request(1'b0, 32'h000C_0000, 8'h00);
    check("dm_cyc", 32'(WBS_CYC), 32'h0);
    check("dm_err_early", 32'(WBM_ERR), 32'h0);
    tick();
    check("dm_err", 32'(WBM_ERR), 32'h1);
    check("dm_ack", 32'(WBM_ACK), 32'h0);
    check("dm_cyc2", 32'(WBS_CYC), 32'h0);
    tick();
    check("dm_err_pulse", 32'(WBM_ERR), 32'h0);
    release_bus();

    // Timeout on silent slave 1; stray responses from other slaves ignored.
    request(1'b0, 32'h0004_0000, 8'h00);
    check("to_cyc", 32'(WBS_CYC), 32'h2);
    WBS_ACK = 3'b001;
    WBS_ERR = 3'b100;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("to_err_early", 32'(WBM_ERR), 32'h0);
      check("to_ack_none",  32'(WBM_ACK), 32'h0);
    end
    check("to_cyc_hold", 32'(WBS_CYC), 32'h2);
    WBS_ACK = 3'b000;
    WBS_ERR = 3'b000;
    tick();
    check("to_err", 32'(WBM_ERR), 32'h1);
    check("to_cyc_clr", 32'(WBS_CYC), 32'h0);
    tick();
    check("to_err_pulse", 32'(WBM_ERR), 32'h0);
    release_bus();

    WBS_RDATA = {8'hEE, 8'h3C, 8'h77};
    request(1'b0, 32'h0000_0000, 8'h00);
    check("post_to_cyc", 32'(WBS_CYC), 32'h1);
    WBS_ACK = 3'b001;
    tick();
    WBS_ACK = 3'b000;
    check("post_to_ack",   32'(WBM_ACK),   32'h1);
    check("post_to_rdata", 32'(WBM_RDATA), 32'h77);
    release_bus();

    // Slave ERR and ACK together: ERR wins, read data not captured.
    request(1'b0, 32'h0008_0000, 8'h00);
    WBS_ACK = 3'b100;
    WBS_ERR = 3'b100;
    tick();
    WBS_ACK = 3'b000;
    WBS_ERR = 3'b000;
    check("se_err",   32'(WBM_ERR),   32'h1);
    check("se_ack",   32'(WBM_ACK),   32'h0);
    check("se_rdata", 32'(WBM_RDATA), 32'h77);
    release_bus();

    // Master abort in BUSY cycle 2.
    request(1'b1, 32'h0008_0000, 8'h01);
    tick();
    WBM_CYC = 1'b0;
    tick();
    check("ab_cyc",   32'(WBS_CYC),   32'h0);
    check("ab_stb",   32'(WBS_STB),   32'h0);
    check("ab_ack",   32'(WBM_ACK),   32'h0);
    check("ab_err",   32'(WBM_ERR),   32'h0);
    check("ab_stall", 32'(WBM_STALL), 32'h0);

    // Reset mid-BUSY; a late slave ACK must not surface.
    WBS_STALL = 3'b010;
    request(1'b1, 32'h0004_0000, 8'h02);
    check("rb_cyc", 32'(WBS_CYC), 32'h2);
    tick();
    RSTN = 1'b0;
    WBM_CYC = 1'b0;
    tick();
    check("rb_cyc_clr", 32'(WBS_CYC), 32'h0);
    check("rb_stb_clr", 32'(WBS_STB), 32'h0);
    check("rb_addr",    WBS_ADDR,     32'h0);
    RSTN = 1'b1;
    WBS_STALL = 3'b000;
    WBS_ACK = 3'b010;
    tick();
    WBS_ACK = 3'b000;
    check("rb_ack",   32'(WBM_ACK),   32'h0);
    check("rb_err",   32'(WBM_ERR),   32'h0);
    check("rb_stall", 32'(WBM_STALL), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
